// File: rtl/cmn_dual_alloc_pool.sv
// Dual-port entry-pool allocator: grants the two lowest free indices per cycle
// and retires up to two releases per cycle, tracking occupancy in registers.
module cmn_dual_alloc_pool #(
   parameter  int ENTRY_NUM = 8,
   localparam int IDX_W     = $clog2(ENTRY_NUM),
   localparam int CNT_W     = $clog2(ENTRY_NUM + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 alloc_req_0,
   output logic                 alloc_rdy_0,
   output logic [IDX_W-1:0]     alloc_idx_0,
   input  logic                 alloc_req_1,
   output logic                 alloc_rdy_1,
   output logic [IDX_W-1:0]     alloc_idx_1,
   input  logic                 rel_vld_0,
   input  logic [IDX_W-1:0]     rel_idx_0,
   input  logic                 rel_vld_1,
   input  logic [IDX_W-1:0]     rel_idx_1,
   output logic [ENTRY_NUM-1:0] occ_vec,
   output logic [CNT_W-1:0]     occ_cnt,
   output logic                 full,
   output logic                 empty,
   output logic                 err_bad_rel
);

   // Returns {found, index} of the lowest set bit of vec.
   function automatic logic [IDX_W:0] find_lowest(input logic [ENTRY_NUM-1:0] vec);
      logic [IDX_W:0] res;
      res = {(IDX_W+1){1'b0}};
      for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
         if (vec[i]) begin
            res = {1'b1, IDX_W'(i)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   logic [ENTRY_NUM-1:0] occ_r, occ_next_s;
   logic [CNT_W-1:0]     cnt_r;
   logic [CNT_W:0]       cnt_next_s;
   logic                 full_r, empty_r, err_r;
   logic                 full_next_s, empty_next_s, err_next_s;
   logic [ENTRY_NUM-1:0] free_s, free2_s, alloc_set_s, rel_clr_s;
   logic [IDX_W:0]       low1_s, low2_s;
   logic                 fire0_s, fire1_s, ok0_s, ok1_s;
   logic [1:0]           n_rel_s;

   // Free-entry search and combinational grants from registered state.
   always_comb begin
      free_s      = ~occ_r;
      low1_s      = find_lowest(free_s);
      free2_s     = free_s & ~(ENTRY_NUM'(1'b1) << low1_s[IDX_W-1:0]);
      low2_s      = find_lowest(free2_s);
      alloc_idx_0 = low1_s[IDX_W-1:0];
      alloc_rdy_0 = low1_s[IDX_W] & ~flush;
      if (alloc_req_0) begin
         alloc_idx_1 = low2_s[IDX_W-1:0];
         alloc_rdy_1 = low2_s[IDX_W] & ~flush;
      end else begin
         alloc_idx_1 = low1_s[IDX_W-1:0];
         alloc_rdy_1 = low1_s[IDX_W] & ~flush;
      end
   end

   // Next-state computation for occupancy, count, flags and the error latch.
   always_comb begin
      fire0_s     = alloc_req_0 & alloc_rdy_0;
      fire1_s     = alloc_req_1 & alloc_rdy_1;
      alloc_set_s = {ENTRY_NUM{1'b0}};
      if (fire0_s) begin
         alloc_set_s = alloc_set_s | (ENTRY_NUM'(1'b1) << alloc_idx_0);
      end else begin
         alloc_set_s = alloc_set_s;
      end
      if (fire1_s) begin
         alloc_set_s = alloc_set_s | (ENTRY_NUM'(1'b1) << alloc_idx_1);
      end else begin
         alloc_set_s = alloc_set_s;
      end
      // Out-of-range indices are rejected before the occupancy bit is looked at.
      ok0_s     = rel_vld_0 && (32'(rel_idx_0) < ENTRY_NUM) && occ_r[rel_idx_0];
      ok1_s     = rel_vld_1 && (32'(rel_idx_1) < ENTRY_NUM) && occ_r[rel_idx_1];
      rel_clr_s = {ENTRY_NUM{1'b0}};
      if (ok0_s) begin
         rel_clr_s = rel_clr_s | (ENTRY_NUM'(1'b1) << rel_idx_0);
      end else begin
         rel_clr_s = rel_clr_s;
      end
      if (ok1_s) begin
         rel_clr_s = rel_clr_s | (ENTRY_NUM'(1'b1) << rel_idx_1);
      end else begin
         rel_clr_s = rel_clr_s;
      end
      n_rel_s = {1'b0, ok0_s} + {1'b0, ok1_s & ~(ok0_s & (rel_idx_0 == rel_idx_1))};
      if (flush) begin
         occ_next_s = {ENTRY_NUM{1'b0}};
         cnt_next_s = {(CNT_W+1){1'b0}};
         err_next_s = err_r;
      end else begin
         occ_next_s = (occ_r | alloc_set_s) & ~rel_clr_s;
         cnt_next_s = {1'b0, cnt_r} + (CNT_W+1)'(fire0_s) + (CNT_W+1)'(fire1_s)
                      - (CNT_W+1)'(n_rel_s);
         err_next_s = err_r | (rel_vld_0 & ~ok0_s) | (rel_vld_1 & ~ok1_s);
      end
      full_next_s  = (cnt_next_s == (CNT_W+1)'(ENTRY_NUM));
      empty_next_s = (cnt_next_s == {(CNT_W+1){1'b0}});
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_r   <= {ENTRY_NUM{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         full_r  <= 1'b0;
         empty_r <= 1'b1;
         err_r   <= 1'b0;
      end else begin
         occ_r   <= occ_next_s;
         cnt_r   <= cnt_next_s[CNT_W-1:0];
         full_r  <= full_next_s;
         empty_r <= empty_next_s;
         err_r   <= err_next_s;
      end
   end

   assign occ_vec     = occ_r;
   assign occ_cnt     = cnt_r;
   assign full        = full_r;
   assign empty       = empty_r;
   assign err_bad_rel = err_r;

endmodule

// File: tb/tb_cmn_dual_alloc_pool.sv
// Scoreboard bench for cmn_dual_alloc_pool: a free-list model predicts each
// cycle's grants and state; a negedge monitor pops and compares.
module tb_cmn_dual_alloc_pool;
   localparam int N  = 8;
   localparam int IW = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n, flush, req0, req1, vld0, vld1;
   logic [IW-1:0] ridx0, ridx1;
   logic          rdy0, rdy1, full, empty, err;
   logic [IW-1:0] idx0, idx1;
   logic [N-1:0]  occ_vec;
   logic [CW-1:0] occ_cnt;

   cmn_dual_alloc_pool #(.ENTRY_NUM(N)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .alloc_req_0(req0), .alloc_rdy_0(rdy0), .alloc_idx_0(idx0),
      .alloc_req_1(req1), .alloc_rdy_1(rdy1), .alloc_idx_1(idx1),
      .rel_vld_0(vld0), .rel_idx_0(ridx0), .rel_vld_1(vld1), .rel_idx_1(ridx1),
      .occ_vec(occ_vec), .occ_cnt(occ_cnt), .full(full), .empty(empty),
      .err_bad_rel(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rdy0, rdy1;
      logic [IW-1:0] idx0, idx1;
      logic [N-1:0]  occ;
      logic [CW-1:0] cnt;
      logic          full, empty, err;
   } exp_t;

   exp_t q[$];
   bit   m_occ[N];
   bit   m_err;
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (m_occ[i]) m_occ[i] = 1'b0;
      m_err = 1'b0;
   endtask

   // One clock cycle: drive inputs, predict outputs, advance the model.
   task automatic cycle(input logic fl, input logic r0, input logic r1,
                        input logic v0, input int i0, input logic v1, input int i1);
      exp_t e;
      int   fl_list[$];
      int   cnt;
      bit   pre[N];
      flush = fl; req0 = r0; req1 = r1;
      vld0 = v0; ridx0 = IW'(i0); vld1 = v1; ridx1 = IW'(i1);
      cnt = 0;
      for (int k = 0; k < N; k++) begin
         e.occ[k] = m_occ[k];
         if (m_occ[k]) cnt++;
         else fl_list.push_back(k);
      end
      e.cnt   = CW'(cnt);
      e.full  = (cnt == N);
      e.empty = (cnt == 0);
      e.err   = m_err;
      e.rdy0  = !fl && fl_list.size() >= 1;
      e.idx0  = (fl_list.size() >= 1) ? IW'(fl_list[0]) : '0;
      e.rdy1  = !fl && (r0 ? fl_list.size() >= 2 : fl_list.size() >= 1);
      e.idx1  = r0 ? ((fl_list.size() >= 2) ? IW'(fl_list[1]) : '0) : e.idx0;
      q.push_back(e);
      if (fl) begin
         foreach (m_occ[k]) m_occ[k] = 1'b0;
      end else begin
         pre = m_occ;
         if (r0 && e.rdy0) m_occ[e.idx0] = 1'b1;
         if (r1 && e.rdy1) m_occ[e.idx1] = 1'b1;
         if (v0) begin
            if (i0 < N && pre[i0]) m_occ[i0] = 1'b0;
            else m_err = 1'b1;
         end
         if (v1) begin
            if (i1 < N && pre[i1]) m_occ[i1] = 1'b0;
            else m_err = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare DUT outputs with the queued expectation mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("rdy0", 32'(rdy0), 32'(e.rdy0));
         chk("rdy1", 32'(rdy1), 32'(e.rdy1));
         if (e.rdy0) chk("idx0", 32'(idx0), 32'(e.idx0));
         if (e.rdy1) chk("idx1", 32'(idx1), 32'(e.idx1));
         chk("occ_vec", 32'(occ_vec), 32'(e.occ));
         chk("occ_cnt", 32'(occ_cnt), 32'(e.cnt));
         chk("full", 32'(full), 32'(e.full));
         chk("empty", 32'(empty), 32'(e.empty));
         chk("err_bad_rel", 32'(err), 32'(e.err));
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_occ"}, 32'(occ_vec), 32'h0);
      chk({tag, "_cnt"}, 32'(occ_cnt), 32'h0);
      chk({tag, "_empty"}, 32'(empty), 32'h1);
      chk({tag, "_full"}, 32'(full), 32'h0);
      chk({tag, "_err"}, 32'(err), 32'h0);
      chk({tag, "_rdy0"}, 32'(rdy0), 32'h1);
      chk({tag, "_rdy1"}, 32'(rdy1), 32'h1);
      chk({tag, "_idx0"}, 32'(idx0), 32'h0);
      chk({tag, "_idx1"}, 32'(idx1), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; req0 = 1'b0; req1 = 1'b0;
      vld0 = 1'b0; vld1 = 1'b0; ridx0 = '0; ridx1 = '0;
      model_reset();
      #12;
      chk_reset_vals("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Fill: grants (0,1),(2,3),(4,5),(6,7), then full with no grants.
      for (int k = 0; k < 4; k++) cycle(0, 1, 1, 0, 0, 0, 0);
      chk("fill_occ", 32'(occ_vec), 32'hFF);
      chk("fill_full", 32'(full), 32'h1);
      cycle(0, 1, 1, 0, 0, 0, 0);

      // 8'hFE with both requesting: only port 0 granted.
      cycle(0, 0, 0, 1, 0, 0, 0);
      chk("fe_occ", 32'(occ_vec), 32'hFE);
      cycle(0, 1, 1, 0, 0, 0, 0);
      chk("fe_after_occ", 32'(occ_vec), 32'hFF);
      chk("fe_after_cnt", 32'(occ_cnt), 32'h8);

      // Release without bypass, then regrant of index 3.
      cycle(0, 1, 0, 1, 3, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      chk("regrant_occ", 32'(occ_vec), 32'hFF);

      // 8'h0F, double release of index 2 counts once.
      cycle(1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) cycle(0, 1, 0, 0, 0, 0, 0);
      chk("0f_occ", 32'(occ_vec), 32'h0F);
      cycle(0, 0, 0, 1, 2, 1, 2);
      chk("dup_occ", 32'(occ_vec), 32'h0B);
      chk("dup_cnt", 32'(occ_cnt), 32'h3);
      chk("dup_err", 32'(err), 32'h0);

      // Bad release sets sticky error, which survives flush.
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 5, 0, 0);
      chk("bad_occ", 32'(occ_vec), 32'h01);
      chk("bad_err", 32'(err), 32'h1);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("flush_err", 32'(err), 32'h1);

      // 8'h3C, flush beats alloc and release.
      for (int k = 0; k < 3; k++) cycle(0, 1, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 1, 1);
      chk("3c_occ", 32'(occ_vec), 32'h3C);
      cycle(1, 1, 0, 1, 2, 0, 0);
      chk("flush_occ", 32'(occ_vec), 32'h0);
      chk("flush_empty", 32'(empty), 32'h1);

      // Randomized traffic.
      for (int k = 0; k < 1500; k++) begin
         cycle(($urandom_range(31) == 0), $urandom_range(1), $urandom_range(1),
               ($urandom_range(2) == 0), $urandom_range(N-1),
               ($urandom_range(2) == 0), $urandom_range(N-1));
      end

      // Asynchronous reset mid-sequence.
      for (int k = 0; k < 3; k++) cycle(0, 1, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 7, 0, 0);
      flush = 1'b0; req0 = 1'b0; req1 = 1'b0; vld0 = 1'b0; vld1 = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midreset");
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 300; k++) begin
         cycle(($urandom_range(63) == 0), $urandom_range(1), $urandom_range(1),
               ($urandom_range(1) == 0), $urandom_range(N-1),
               ($urandom_range(3) == 0), $urandom_range(N-1));
      end
      cycle(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); #1;
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
